sim_result_checker: RTL and testbench
=====================================

Name: sim_result_checker

Overview:
- Synthesisable end-of-run checker for the CPU + IM/DM SRAM harness; replaces ad-hoc bench polling so the same check runs in RTL, gate-level (SDF) and FPGA builds.
- Snoops the DM write port for the end-of-simulation code and counts cycles, with a timeout.
- On end or timeout, takes the DM read port and scans a result region against a golden ROM.
- Reports pass/fail, error count, cycle count and a per-mismatch stream.

Parameters:
- ADDR_W, 14, word-address width (DM addr[15:2])
- DATA_W, 32, data word width
- BE_W, 4, byte-enable width (DATA_W/8)
- END_ADDR, 14'h3fff, word address watched for the end code
- END_CODE, 32'hffffffff, end-of-simulation value
- TEST_START, 14'h2000, first word address of the result region
- NUM_WORDS, 64, words compared (1..2^ADDR_W)
- MAX_CYCLES, 150000, timeout in cycles
- CNT_W, 32, cycle-counter width
- ERR_W, 16, error-counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- dm_write  in  BE_W  DM byte write enables (snooped)
- dm_addr  in  ADDR_W  DM word address (snooped)
- dm_din  in  DATA_W  DM write data (snooped)
- scan_req  out  1  checker owns DM read port; external mux selects scan_addr
- scan_addr  out  ADDR_W  DM read word address
- scan_rdata  in  DATA_W  DM read data, valid 1 cycle after address
- gold_addr  out  ADDR_W  golden ROM index (0-based)
- gold_rdata  in  DATA_W  golden data, valid 1 cycle after address
- mis_valid  out  1  one-cycle pulse per mismatch
- mis_idx  out  ADDR_W  index of the mismatching word
- mis_got  out  DATA_W  DM value
- mis_exp  out  DATA_W  golden value
- cycle_count  out  CNT_W  cycles run before end or timeout
- err_count  out  ERR_W  mismatch count, saturating
- done  out  1  result valid (sticky)
- pass  out  1  done && err_count==0 && !timeout
- timeout  out  1  MAX_CYCLES reached without end code (sticky)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN.
  - All outputs 0, including cycle_count, err_count and all mis_* fields.
  - Reset mid-SCAN or in DONE aborts the check; the next run starts fresh.
- RUN:
  - cycle_count increments every cycle.
  - End detect: dm_write==all-ones, dm_addr==END_ADDR and dm_din==END_CODE, sampled on the clock edge.
  - Partial byte writes never trigger end detect.
  - On end detect: cycle_count freezes at its pre-increment value plus one (the count includes the end cycle); state goes to SCAN.
  - If cycle_count reaches MAX_CYCLES-1 with no end detect: timeout=1, cycle_count freezes at MAX_CYCLES, state goes to SCAN.
  - End detect and timeout terminal in the same cycle: end wins, timeout=0.
- SCAN:
  - scan_req=1 for exactly NUM_WORDS cycles.
  - Each cycle issues idx 0..NUM_WORDS-1: scan_addr=(TEST_START+idx) mod 2^ADDR_W, gold_addr=idx.
  - The compare stage runs 1 cycle behind the issue stage. On inequality: mis_valid=1, mis_idx=idx, mis_got=scan_rdata, mis_exp=gold_rdata, and err_count increments.
  - err_count saturates at 2^ERR_W-1.
  - After the final compare, state goes to DONE. Total SCAN duration is NUM_WORDS+1 cycles: scan_req drops one cycle before the last compare.
  - DM writes during SCAN are ignored.
- DONE:
  - done=1; pass is computed and held.
  - All counters and flags stay stable until reset.
  - scan_req=0; mis_valid=0.
- mis_* data fields hold their last value between pulses.
- No combinational path from any input to any output except none. All outputs are registered, except scan_addr, gold_addr and scan_req, which are driven from state/index registers.

Test Plan:
- NUM_WORDS=4, MAX_CYCLES=100. DM holds golden values; at cycle 20, write 0xffffffff to 0x3fff with BE=4'hf -> scan_addr 0x2000..0x2003; done=1, pass=1, err_count=0, cycle_count=20, no mis_valid pulses.
- Same setup, but DM word 0x2002=0x12345678 while golden[2]=0xdeadbeef -> single mis_valid pulse with mis_idx=2, mis_got=0x12345678, mis_exp=0xdeadbeef; err_count=1, pass=0.
- No end write, MAX_CYCLES=100 -> timeout=1, cycle_count=100, scan still runs and done=1; pass=0 even with 0 mismatches.
- Write 0xffffffff to 0x3fff with BE=4'b0011, then a full-word write 5 cycles later -> end detected only on the full-word write; cycle_count reflects the later cycle.
- End write lands on cycle 99 (the timeout terminal) -> timeout=0, scan proceeds normally.
- Pull rst low mid-SCAN at idx 2 -> all outputs 0 immediately; after release, state is RUN and cycle_count restarts from 0.
- ERR_W=2, 4 mismatches -> err_count saturates at 3; 4 mis_valid pulses are still emitted.

Source files
------------

// File: rtl/sim_result_checker.sv
// End-of-run checker: watches DM writes for the end code or a cycle timeout, then
// scans the DM result region against a golden ROM and reports pass/fail.
module sim_result_checker #(
  parameter int                ADDR_W     = 14,
  parameter int                DATA_W     = 32,
  parameter int                BE_W       = 4,
  parameter logic [ADDR_W-1:0] END_ADDR   = 14'h3fff,
  parameter logic [DATA_W-1:0] END_CODE   = 32'hffffffff,
  parameter logic [ADDR_W-1:0] TEST_START = 14'h2000,
  parameter int                NUM_WORDS  = 64,
  parameter int                MAX_CYCLES = 150000,
  parameter int                CNT_W      = 32,
  parameter int                ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BE_W-1:0]   dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_din,
  output logic              scan_req,
  output logic [ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0] scan_rdata,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [DATA_W-1:0] gold_rdata,
  output logic              mis_valid,
  output logic [ADDR_W-1:0] mis_idx,
  output logic [DATA_W-1:0] mis_got,
  output logic [DATA_W-1:0] mis_exp,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_issue;
  logic [ADDR_W-1:0] r_idx;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_idx;

  logic              r_mis_valid;
  logic [ADDR_W-1:0] r_mis_idx;
  logic [DATA_W-1:0] r_mis_got;
  logic [DATA_W-1:0] r_mis_exp;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [ERR_W-1:0]  r_err_count;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;

  logic              w_end_hit;
  logic              w_terminal;
  logic              w_last_issue;
  logic              w_scan_last;
  logic              w_mismatch;

  // Only a full-word write of the end code counts; byte-lane writes are ignored.
  assign w_end_hit    = (dm_write == '1) && (dm_addr == END_ADDR) && (dm_din == END_CODE);
  assign w_terminal   = (r_cycle_count == CNT_W'(MAX_CYCLES - 1));
  assign w_last_issue = (r_idx == ADDR_W'(NUM_WORDS - 1));
  assign w_scan_last  = r_cmp_valid && !r_issue;
  assign w_mismatch   = r_cmp_valid && (scan_rdata != gold_rdata);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_end_hit || w_terminal) w_state_next = ST_SCAN;
      ST_SCAN: if (w_scan_last)             w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_RUN;
    endcase
  end

  // Output logic: read-port ownership and addresses come straight from the issue registers.
  always_comb begin
    scan_req  = 1'b0;
    scan_addr = '0;
    gold_addr = '0;
    if ((r_state == ST_SCAN) && r_issue) begin
      scan_req  = 1'b1;
      scan_addr = TEST_START + r_idx;
      gold_addr = r_idx;
    end
  end

  // Cycle counter, scan issue/compare pipeline and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue       <= 1'b0;
      r_idx         <= '0;
      r_cmp_valid   <= 1'b0;
      r_cmp_idx     <= '0;
      r_mis_valid   <= 1'b0;
      r_mis_idx     <= '0;
      r_mis_got     <= '0;
      r_mis_exp     <= '0;
      r_cycle_count <= '0;
      r_err_count   <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_mis_valid <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_end_hit) begin
            r_cycle_count <= r_cycle_count + 1'b1;
            r_issue       <= 1'b1;
            r_idx         <= '0;
          end else if (w_terminal) begin
            r_cycle_count <= CNT_W'(MAX_CYCLES);
            r_timeout     <= 1'b1;
            r_issue       <= 1'b1;
            r_idx         <= '0;
          end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
          end
        end
        ST_SCAN: begin
          r_cmp_valid <= r_issue;
          if (r_issue) begin
            r_cmp_idx <= r_idx;
            if (w_last_issue) begin
              r_issue <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          if (w_mismatch) begin
            r_mis_valid <= 1'b1;
            r_mis_idx   <= r_cmp_idx;
            r_mis_got   <= scan_rdata;
            r_mis_exp   <= gold_rdata;
            if (r_err_count != '1) begin
              r_err_count <= r_err_count + 1'b1;
            end
          end
          // The final compare may itself mismatch, so fold it into pass here.
          if (w_scan_last) begin
            r_done <= 1'b1;
            r_pass <= !r_timeout && (r_err_count == '0) && !w_mismatch;
          end
        end
        default: ;
      endcase
    end
  end

  assign mis_valid   = r_mis_valid;
  assign mis_idx     = r_mis_idx;
  assign mis_got     = r_mis_got;
  assign mis_exp     = r_mis_exp;
  assign cycle_count = r_cycle_count;
  assign err_count   = r_err_count;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_sim_result_checker.sv
// Directed bench for sim_result_checker: end detect, timeout, mismatch reporting,
// async reset mid-scan and error-count saturation (second instance with ERR_W=2).
module tb_sim_result_checker;

  localparam int                ADDR_W     = 14;
  localparam int                DATA_W     = 32;
  localparam int                BE_W       = 4;
  localparam int                NUM_WORDS  = 4;
  localparam int                MAX_CYCLES = 100;
  localparam int                CNT_W      = 32;
  localparam logic [ADDR_W-1:0] END_ADDR   = 14'h3fff;
  localparam logic [DATA_W-1:0] END_CODE   = 32'hffffffff;
  localparam logic [ADDR_W-1:0] TEST_START = 14'h2000;

  logic              clk;
  logic              rst;
  logic [BE_W-1:0]   dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_din;

  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_rdata;
  logic [ADDR_W-1:0] gold_addr;
  logic [DATA_W-1:0] gold_rdata;
  logic              mis_valid;
  logic [ADDR_W-1:0] mis_idx;
  logic [DATA_W-1:0] mis_got;
  logic [DATA_W-1:0] mis_exp;
  logic [CNT_W-1:0]  cycle_count;
  logic [15:0]       err_count;
  logic              done;
  logic              pass;
  logic              timeout;

  logic              s_scan_req;
  logic [ADDR_W-1:0] s_scan_addr;
  logic [DATA_W-1:0] s_scan_rdata;
  logic [ADDR_W-1:0] s_gold_addr;
  logic [DATA_W-1:0] s_gold_rdata;
  logic              s_mis_valid;
  logic [ADDR_W-1:0] s_mis_idx;
  logic [DATA_W-1:0] s_mis_got;
  logic [DATA_W-1:0] s_mis_exp;
  logic [CNT_W-1:0]  s_cycle_count;
  logic [1:0]        s_err_count;
  logic              s_done;
  logic              s_pass;
  logic              s_timeout;

  logic [DATA_W-1:0] dm   [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] gold [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_edge = 0;
  int pulses   = 0;
  int s_pulses = 0;
  logic [ADDR_W-1:0] addr_log [$];

  sim_result_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .END_ADDR(END_ADDR), .END_CODE(END_CODE),
    .TEST_START(TEST_START), .NUM_WORDS(NUM_WORDS), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W),
    .ERR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .dm_write(dm_write), .dm_addr(dm_addr), .dm_din(dm_din),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_rdata(scan_rdata),
    .gold_addr(gold_addr), .gold_rdata(gold_rdata), .mis_valid(mis_valid),
    .mis_idx(mis_idx), .mis_got(mis_got), .mis_exp(mis_exp), .cycle_count(cycle_count),
    .err_count(err_count), .done(done), .pass(pass), .timeout(timeout)
  );

  sim_result_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .END_ADDR(END_ADDR), .END_CODE(END_CODE),
    .TEST_START(TEST_START), .NUM_WORDS(NUM_WORDS), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W),
    .ERR_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .dm_write(dm_write), .dm_addr(dm_addr), .dm_din(dm_din),
    .scan_req(s_scan_req), .scan_addr(s_scan_addr), .scan_rdata(s_scan_rdata),
    .gold_addr(s_gold_addr), .gold_rdata(s_gold_rdata), .mis_valid(s_mis_valid),
    .mis_idx(s_mis_idx), .mis_got(s_mis_got), .mis_exp(s_mis_exp), .cycle_count(s_cycle_count),
    .err_count(s_err_count), .done(s_done), .pass(s_pass), .timeout(s_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read DM and golden ROM models: data valid one cycle after address.
  always @(posedge clk) begin
    scan_rdata   <= dm[scan_addr];
    gold_rdata   <= gold[gold_addr];
    s_scan_rdata <= dm[s_scan_addr];
    s_gold_rdata <= gold[s_gold_addr];
  end

  always @(negedge clk) begin
    if (rst) begin
      if (mis_valid)   pulses++;
      if (s_mis_valid) s_pulses++;
      if (scan_req)    addr_log.push_back(scan_addr);
    end
  end

  task automatic tick();
    @(negedge clk);
    cur_edge++;
  endtask

  task automatic load_mem(input logic [DATA_W-1:0] dmv [4], input logic [DATA_W-1:0] gv [4]);
    for (int i = 0; i < NUM_WORDS; i++) begin
      dm[TEST_START + ADDR_W'(i)] = dmv[i];
      gold[i]                     = gv[i];
    end
  endtask

  // Reset both instances and release on a falling edge; cur_edge counts rising edges since.
  task automatic start_run();
    rst      = 1'b0;
    dm_write = '0;
    dm_addr  = '0;
    dm_din   = '0;
    @(negedge clk);
    @(negedge clk);
    pulses   = 0;
    s_pulses = 0;
    addr_log.delete();
    rst      = 1'b1;
    cur_edge = 0;
  endtask

  // Present a write so that it is sampled on rising edge k after reset release.
  task automatic write_at(input int k, input logic [BE_W-1:0] be, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    while (cur_edge < k - 1) tick();
    dm_write = be;
    dm_addr  = a;
    dm_din   = d;
    tick();
    dm_write = '0;
    dm_addr  = '0;
    dm_din   = '0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_wait: done=%0b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({scan_req, scan_addr, gold_addr, mis_valid, mis_idx, mis_got, mis_exp, cycle_count,
         err_count, done, pass, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cycle_count=%0d err_count=%0d done=%0b scan_req=%0b, required all 0",
               cycle_count, err_count, done, scan_req);
    end
  endtask

  task automatic test_pass();
    logic [DATA_W-1:0] v [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [CNT_W-1:0]  held;
    load_mem(v, v);
    start_run();
    write_at(20, 4'hf, END_ADDR, END_CODE);
    repeat (4) tick();
    n_checks++;
    if ({scan_req, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL pass_last_compare: scan_req=%0b done=%0b, required 0 0", scan_req, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_done_latency: done=%0b, required 1 at end+5", done);
    end
    n_checks++;
    if ({pass, timeout, err_count} !== {1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL pass_flags: pass=%0b timeout=%0b err=%0d, required 1 0 0", pass, timeout, err_count);
    end
    n_checks++;
    if (cycle_count !== 32'd20) begin
      n_fail++;
      $display("FAIL pass_cycle_count: got %0d, required 20", cycle_count);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL pass_no_pulses: got %0d pulses, required 0", pulses);
    end
    n_checks++;
    if (addr_log.size() !== NUM_WORDS) begin
      n_fail++;
      $display("FAIL pass_scan_len: got %0d scan_req cycles, required %0d", addr_log.size(), NUM_WORDS);
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        n_checks++;
        if (addr_log[i] !== TEST_START + ADDR_W'(i)) begin
          n_fail++;
          $display("FAIL pass_scan_addr%0d: got 0x%h, required 0x%h", i, addr_log[i], TEST_START + ADDR_W'(i));
        end
      end
    end
    held = cycle_count;
    write_at(cur_edge + 2, 4'hf, END_ADDR, END_CODE);
    repeat (8) tick();
    n_checks++;
    if ({cycle_count, done, pass, scan_req} !== {held, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL done_stable: cycle=%0d done=%0b pass=%0b scan_req=%0b, required %0d 1 1 0",
               cycle_count, done, pass, scan_req, held);
    end
  endtask

  task automatic test_mismatch();
    logic [DATA_W-1:0] g [4] = '{32'h11111111, 32'h22222222, 32'hdeadbeef, 32'h44444444};
    logic [DATA_W-1:0] d [4] = '{32'h11111111, 32'h22222222, 32'h12345678, 32'h44444444};
    load_mem(d, g);
    start_run();
    write_at(20, 4'hf, END_ADDR, END_CODE);
    wait_done("mismatch");
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL mismatch_pulses: got %0d, required 1", pulses);
    end
    n_checks++;
    if ({mis_idx, mis_got, mis_exp} !== {14'd2, 32'h12345678, 32'hdeadbeef}) begin
      n_fail++;
      $display("FAIL mismatch_fields: idx=%0d got=0x%h exp=0x%h, required 2 0x12345678 0xdeadbeef",
               mis_idx, mis_got, mis_exp);
    end
    n_checks++;
    if ({err_count, pass, mis_valid} !== {16'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mismatch_result: err=%0d pass=%0b mis_valid=%0b, required 1 0 0", err_count, pass, mis_valid);
    end
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] v [4] = '{32'ha, 32'hb, 32'hc, 32'hd};
    load_mem(v, v);
    start_run();
    wait_done("timeout");
    n_checks++;
    if ({timeout, pass, err_count, cycle_count} !== {1'b1, 1'b0, 16'd0, 32'd100}) begin
      n_fail++;
      $display("FAIL timeout_result: timeout=%0b pass=%0b err=%0d cycle=%0d, required 1 0 0 100",
               timeout, pass, err_count, cycle_count);
    end
    n_checks++;
    if (addr_log.size() !== NUM_WORDS) begin
      n_fail++;
      $display("FAIL timeout_scan_len: got %0d, required %0d", addr_log.size(), NUM_WORDS);
    end
  endtask

  task automatic test_partial_write();
    logic [DATA_W-1:0] v [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
    load_mem(v, v);
    start_run();
    write_at(10, 4'b0011, END_ADDR, END_CODE);
    write_at(15, 4'hf, END_ADDR, END_CODE);
    wait_done("partial");
    n_checks++;
    if ({cycle_count, pass, timeout} !== {32'd15, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL partial_write: cycle=%0d pass=%0b timeout=%0b, required 15 1 0", cycle_count, pass, timeout);
    end
  endtask

  task automatic test_end_at_terminal();
    logic [DATA_W-1:0] v [4] = '{32'h5, 32'h6, 32'h7, 32'h8};
    load_mem(v, v);
    start_run();
    write_at(MAX_CYCLES, 4'hf, END_ADDR, END_CODE);
    wait_done("terminal");
    n_checks++;
    if ({timeout, pass, cycle_count} !== {1'b0, 1'b1, 32'd100}) begin
      n_fail++;
      $display("FAIL end_at_terminal: timeout=%0b pass=%0b cycle=%0d, required 0 1 100", timeout, pass, cycle_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [DATA_W-1:0] g [4] = '{32'hcafe0000, 32'h2, 32'h3, 32'h4};
    logic [DATA_W-1:0] d [4] = '{32'h0000cafe, 32'h2, 32'h3, 32'h4};
    int n;
    load_mem(d, g);
    start_run();
    write_at(10, 4'hf, END_ADDR, END_CODE);
    n = 0;
    while (!(scan_req && gold_addr == 14'd2) && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL midscan_pre_err: got %0d, required 1 before reset", err_count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({scan_req, scan_addr, gold_addr, mis_valid, mis_idx, mis_got, mis_exp, cycle_count,
         err_count, done, pass, timeout} !== '0) begin
      n_fail++;
      $display("FAIL midscan_reset: cycle=%0d err=%0d mis_got=0x%h scan_req=%0b, required all 0",
               cycle_count, err_count, mis_got, scan_req);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({cycle_count, done, scan_req} !== {32'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midscan_restart: cycle=%0d done=%0b scan_req=%0b, required 5 0 0", cycle_count, done, scan_req);
    end
  endtask

  task automatic test_saturate();
    logic [DATA_W-1:0] g [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
    logic [DATA_W-1:0] d [4] = '{32'h11, 32'h21, 32'h31, 32'h41};
    load_mem(d, g);
    start_run();
    write_at(12, 4'hf, END_ADDR, END_CODE);
    wait_done("saturate");
    tick();
    n_checks++;
    if ({s_done, s_err_count, s_pass} !== {1'b1, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_err_count: done=%0b err=%0d pass=%0b, required 1 3 0", s_done, s_err_count, s_pass);
    end
    n_checks++;
    if (s_pulses !== 4) begin
      n_fail++;
      $display("FAIL sat_pulses: got %0d, required 4", s_pulses);
    end
    n_checks++;
    if ({err_count, s_mis_idx, s_mis_got, s_mis_exp} !== {16'd4, 14'd3, 32'h41, 32'h40}) begin
      n_fail++;
      $display("FAIL sat_wide_err: err=%0d idx=%0d got=0x%h exp=0x%h, required 4 3 0x41 0x40",
               err_count, s_mis_idx, s_mis_got, s_mis_exp);
    end
  endtask

  initial begin
    rst      = 1'b0;
    dm_write = '0;
    dm_addr  = '0;
    dm_din   = '0;
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_partial_write();
    test_end_at_terminal();
    test_reset_mid_scan();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
